// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes to 16 general and 4 predicate registers and stalls decode on hazards.
// Define SCOREBOARD_BYPASS_EN to let a same-cycle writeback release its register for the hazard check.
module reg_scoreboard #(
    parameter int MAX_INFLIGHT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    input  logic [3:0]  iss_rx,
    input  logic        iss_rx_en,
    input  logic [3:0]  iss_ry,
    input  logic        iss_ry_en,
    input  logic [1:0]  iss_px,
    input  logic [1:0]  iss_py,
    input  logic        iss_p_en,
    input  logic [1:0]  iss_pguard,
    input  logic        iss_pguard_en,
    input  logic [3:0]  iss_dst,
    input  logic [1:0]  iss_dst_kind,
    input  logic        wb_greg_valid,
    input  logic [3:0]  wb_greg_id,
    input  logic        wb_preg_valid,
    input  logic [1:0]  wb_preg_id,
    input  logic        flush,
    output logic        stall,
    output logic        fire,
    output logic [15:0] greg_busy,
    output logic [3:0]  preg_busy,
    output logic [2:0]  inflight
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

    logic [15:0] r_greg_busy;
    logic [3:0]  r_preg_busy;
    logic [2:0]  r_inflight;

    logic        w_kind_greg;
    logic        w_kind_preg;
    logic        w_wb_greg_hit;
    logic        w_wb_preg_hit;
    logic [15:0] w_greg_clr;
    logic [3:0]  w_preg_clr;
    logic [15:0] w_greg_set;
    logic [3:0]  w_preg_set;
    logic [15:0] w_greg_view;
    logic [3:0]  w_preg_view;
    logic        w_hazard;
    logic        w_full;
    logic [4:0]  w_sum;
    logic [2:0]  w_inflight_next;

    assign w_kind_greg = (iss_dst_kind == 2'b01);
    assign w_kind_preg = (iss_dst_kind == 2'b10);

    // Writebacks only count when they hit a register that is actually tracked as busy.
    assign w_wb_greg_hit = wb_greg_valid & r_greg_busy[wb_greg_id];
    assign w_wb_preg_hit = wb_preg_valid & r_preg_busy[wb_preg_id];
    assign w_greg_clr    = w_wb_greg_hit ? (16'h0001 << wb_greg_id) : 16'h0000;
    assign w_preg_clr    = w_wb_preg_hit ? (4'h1 << wb_preg_id) : 4'h0;

`ifdef SCOREBOARD_BYPASS_EN
    assign w_greg_view = r_greg_busy & ~w_greg_clr;
    assign w_preg_view = r_preg_busy & ~w_preg_clr;
`else
    assign w_greg_view = r_greg_busy;
    assign w_preg_view = r_preg_busy;
`endif

    assign w_hazard = (iss_rx_en & w_greg_view[iss_rx])
                    | (iss_ry_en & w_greg_view[iss_ry])
                    | (iss_p_en & (w_preg_view[iss_px] | w_preg_view[iss_py]))
                    | (iss_pguard_en & w_preg_view[iss_pguard])
                    | (w_kind_greg & w_greg_view[iss_dst])
                    | (w_kind_preg & w_preg_view[iss_dst[1:0]]);

    assign w_full = (r_inflight == MAX_CNT) & (w_kind_greg | w_kind_preg);

    assign stall = iss_valid & (w_hazard | w_full | flush);
    assign fire  = iss_valid & ~stall;

    assign w_greg_set = (fire & w_kind_greg) ? (16'h0001 << iss_dst) : 16'h0000;
    assign w_preg_set = (fire & w_kind_preg) ? (4'h1 << iss_dst[1:0]) : 4'h0;

    // Net occupancy change, clamped so a corrupted count can never wrap.
    always_comb begin
        w_sum = {2'b00, r_inflight}
              + {4'b0000, fire & (w_kind_greg | w_kind_preg)}
              - {4'b0000, w_wb_greg_hit}
              - {4'b0000, w_wb_preg_hit};
        w_inflight_next = w_sum[2:0];
        if (w_sum[4]) begin
            w_inflight_next = 3'd0;
        end else if (w_sum[3:0] > {1'b0, MAX_CNT}) begin
            w_inflight_next = MAX_CNT;
        end
    end

    // Set after clear so a fire and a writeback to the same register leave it busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_greg_busy <= 16'h0000;
            r_preg_busy <= 4'h0;
            r_inflight  <= 3'd0;
        end else if (flush) begin
            r_greg_busy <= 16'h0000;
            r_preg_busy <= 4'h0;
            r_inflight  <= 3'd0;
        end else begin
            r_greg_busy <= (r_greg_busy & ~w_greg_clr) | w_greg_set;
            r_preg_busy <= (r_preg_busy & ~w_preg_clr) | w_preg_set;
            r_inflight  <= w_inflight_next;
        end
    end

    assign greg_busy = r_greg_busy;
    assign preg_busy = r_preg_busy;
    assign inflight  = r_inflight;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table-driven bench for reg_scoreboard (MAX_INFLIGHT = 6), plus reset corner sequences.
module tb_reg_scoreboard;

    typedef struct {
        string       name;
        logic        valid;
        logic [3:0]  rx;
        logic        rxEn;
        logic [3:0]  ry;
        logic        ryEn;
        logic [1:0]  px;
        logic [1:0]  py;
        logic        pEn;
        logic [1:0]  pg;
        logic        pgEn;
        logic [3:0]  dst;
        logic [1:0]  kind;
        logic        wbG;
        logic [3:0]  wbGId;
        logic        wbP;
        logic [1:0]  wbPId;
        logic        fl;
        logic        expStall;
        logic        expFire;
        logic [15:0] expGreg;
        logic [3:0]  expPreg;
        logic [2:0]  expInfl;
    } vec_t;

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [3:0]  iss_rx;
    logic        iss_rx_en;
    logic [3:0]  iss_ry;
    logic        iss_ry_en;
    logic [1:0]  iss_px;
    logic [1:0]  iss_py;
    logic        iss_p_en;
    logic [1:0]  iss_pguard;
    logic        iss_pguard_en;
    logic [3:0]  iss_dst;
    logic [1:0]  iss_dst_kind;
    logic        wb_greg_valid;
    logic [3:0]  wb_greg_id;
    logic        wb_preg_valid;
    logic [1:0]  wb_preg_id;
    logic        flush;
    logic        stall;
    logic        fire;
    logic [15:0] greg_busy;
    logic [3:0]  preg_busy;
    logic [2:0]  inflight;

    int testsRun = 0;
    int testsFailed = 0;
    vec_t vecs[$];

    reg_scoreboard #(.MAX_INFLIGHT(6)) dut (
        .clk(clk), .rst(rst), .iss_valid(iss_valid),
        .iss_rx(iss_rx), .iss_rx_en(iss_rx_en), .iss_ry(iss_ry), .iss_ry_en(iss_ry_en),
        .iss_px(iss_px), .iss_py(iss_py), .iss_p_en(iss_p_en),
        .iss_pguard(iss_pguard), .iss_pguard_en(iss_pguard_en),
        .iss_dst(iss_dst), .iss_dst_kind(iss_dst_kind),
        .wb_greg_valid(wb_greg_valid), .wb_greg_id(wb_greg_id),
        .wb_preg_valid(wb_preg_valid), .wb_preg_id(wb_preg_id),
        .flush(flush), .stall(stall), .fire(fire),
        .greg_busy(greg_busy), .preg_busy(preg_busy), .inflight(inflight)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string n, logic v, logic [3:0] rx, logic rxE, logic [3:0] ry, logic ryE,
                                logic [1:0] px, logic [1:0] py, logic pE, logic [1:0] pg, logic pgE,
                                logic [3:0] dst, logic [1:0] k, logic wG, logic [3:0] wGi,
                                logic wP, logic [1:0] wPi, logic fl, logic eS, logic eF,
                                logic [15:0] eG, logic [3:0] eP, logic [2:0] eI);
        vec_t t;
        t.name = n; t.valid = v; t.rx = rx; t.rxEn = rxE; t.ry = ry; t.ryEn = ryE;
        t.px = px; t.py = py; t.pEn = pE; t.pg = pg; t.pgEn = pgE; t.dst = dst; t.kind = k;
        t.wbG = wG; t.wbGId = wGi; t.wbP = wP; t.wbPId = wPi; t.fl = fl;
        t.expStall = eS; t.expFire = eF; t.expGreg = eG; t.expPreg = eP; t.expInfl = eI;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t t);
        iss_valid = t.valid; iss_rx = t.rx; iss_rx_en = t.rxEn; iss_ry = t.ry; iss_ry_en = t.ryEn;
        iss_px = t.px; iss_py = t.py; iss_p_en = t.pEn; iss_pguard = t.pg; iss_pguard_en = t.pgEn;
        iss_dst = t.dst; iss_dst_kind = t.kind;
        wb_greg_valid = t.wbG; wb_greg_id = t.wbGId; wb_preg_valid = t.wbP; wb_preg_id = t.wbPId;
        flush = t.fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle: check the combinational handshake, then the registered state after the edge.
    task automatic runVec(input vec_t t);
        applyStimulus(t);
        #1;
        checkOutput({t.name, ".stall"}, 32'(stall), 32'(t.expStall));
        checkOutput({t.name, ".fire"}, 32'(fire), 32'(t.expFire));
        @(posedge clk);
        #1;
        checkOutput({t.name, ".greg"}, 32'(greg_busy), 32'(t.expGreg));
        checkOutput({t.name, ".preg"}, 32'(preg_busy), 32'(t.expPreg));
        checkOutput({t.name, ".infl"}, 32'(inflight), 32'(t.expInfl));
    endtask

    initial begin
        vec_t idle;
        idle = mk("idle", 0, 0,0, 0,0, 0,0,0, 0,0, 0,2'b00, 0,0, 0,0, 0, 0,0, 16'h0, 4'h0, 3'd0);

        //           name            v rx rxE ry ryE px py pE pg pgE dst kind  wG wGi wP wPi fl  S     F     greg      preg infl
        vecs.push_back(mk("fire_g3",   1, 0,0, 0,0, 0,0,0, 0,0, 3,2'b01, 0,0, 0,0, 0, 0,1, 16'h0008,4'h0,3'd1));
        vecs.push_back(mk("rx_haz",    1, 3,1, 0,0, 0,0,0, 0,0, 0,2'b00, 0,0, 0,0, 0, 1,0, 16'h0008,4'h0,3'd1));
        vecs.push_back(mk("rx_wb",     1, 3,1, 0,0, 0,0,0, 0,0, 0,2'b00, 1,3, 0,0, 0, !BYP,BYP, 16'h0000,4'h0,3'd0));
        vecs.push_back(mk("rx_retry",  1, 3,1, 0,0, 0,0,0, 0,0, 0,2'b00, 0,0, 0,0, 0, 0,1, 16'h0000,4'h0,3'd0));
        vecs.push_back(mk("fire_g7",   1, 0,0, 0,0, 0,0,0, 0,0, 7,2'b01, 0,0, 0,0, 0, 0,1, 16'h0080,4'h0,3'd1));
        vecs.push_back(mk("ry_haz",    1, 0,0, 7,1, 0,0,0, 0,0, 0,2'b00, 0,0, 0,0, 0, 1,0, 16'h0080,4'h0,3'd1));
        vecs.push_back(mk("fire_p2",   1, 7,0, 7,0, 0,0,0, 0,0, 2,2'b10, 0,0, 0,0, 0, 0,1, 16'h0080,4'h4,3'd2));
        vecs.push_back(mk("pg_haz",    1, 0,0, 0,0, 0,0,0, 2,1, 0,2'b00, 0,0, 0,0, 0, 1,0, 16'h0080,4'h4,3'd2));
        vecs.push_back(mk("px_haz",    1, 0,0, 0,0, 2,0,1, 0,0, 0,2'b00, 0,0, 0,0, 0, 1,0, 16'h0080,4'h4,3'd2));
        vecs.push_back(mk("pxy_ok",    1, 0,0, 0,0, 1,3,1, 0,0, 0,2'b00, 0,0, 0,0, 0, 0,1, 16'h0080,4'h4,3'd2));
        vecs.push_back(mk("waw_g",     1, 0,0, 0,0, 0,0,0, 0,0, 7,2'b01, 0,0, 0,0, 0, 1,0, 16'h0080,4'h4,3'd2));
        vecs.push_back(mk("waw_p",     1, 0,0, 0,0, 0,0,0, 0,0, 6,2'b10, 0,0, 0,0, 0, 1,0, 16'h0080,4'h4,3'd2));
        vecs.push_back(mk("kind11",    1, 0,0, 0,0, 0,0,0, 0,0, 7,2'b11, 0,0, 0,0, 0, 0,1, 16'h0080,4'h4,3'd2));
        vecs.push_back(mk("wb_two",    0, 0,0, 0,0, 0,0,0, 0,0, 0,2'b00, 1,7, 1,2, 0, 0,0, 16'h0000,4'h0,3'd0));
        vecs.push_back(mk("wb_idle",   0, 0,0, 0,0, 0,0,0, 0,0, 0,2'b00, 1,9, 0,0, 0, 0,0, 16'h0000,4'h0,3'd0));
        for (int i = 0; i < 6; i++) begin
            vecs.push_back(mk($sformatf("fill_g%0d", i), 1, 0,0, 0,0, 0,0,0, 0,0, 4'(i),2'b01, 0,0, 0,0, 0,
                              0,1, 16'((1 << (i + 1)) - 1),4'h0,3'(i + 1)));
        end
        vecs.push_back(mk("full_g",    1, 0,0, 0,0, 0,0,0, 0,0, 8,2'b01, 0,0, 0,0, 0, 1,0, 16'h003F,4'h0,3'd6));
        vecs.push_back(mk("full_p",    1, 0,0, 0,0, 0,0,0, 0,0, 0,2'b10, 0,0, 0,0, 0, 1,0, 16'h003F,4'h0,3'd6));
        vecs.push_back(mk("full_none", 1, 0,0, 0,0, 0,0,0, 0,0, 8,2'b00, 0,0, 0,0, 0, 0,1, 16'h003F,4'h0,3'd6));
        vecs.push_back(mk("wb_g0",     0, 0,0, 0,0, 0,0,0, 0,0, 0,2'b00, 1,0, 0,0, 0, 0,0, 16'h003E,4'h0,3'd5));
        vecs.push_back(mk("fire_wb_g5",1, 0,0, 0,0, 0,0,0, 0,0, 5,2'b01, 1,5, 0,0, 0, !BYP,BYP,
                          BYP ? 16'h003E : 16'h001E, 4'h0, BYP ? 3'd5 : 3'd4));
        vecs.push_back(mk("wb_g9_idle",0, 0,0, 0,0, 0,0,0, 0,0, 0,2'b00, 1,9, 0,0, 0, 0,0,
                          BYP ? 16'h003E : 16'h001E, 4'h0, BYP ? 3'd5 : 3'd4));
        vecs.push_back(mk("flush",     1, 0,0, 0,0, 0,0,0, 0,0,10,2'b01, 1,1, 0,0, 1, 1,0, 16'h0000,4'h0,3'd0));
        vecs.push_back(mk("fire_g1",   1, 0,0, 0,0, 0,0,0, 0,0, 1,2'b01, 0,0, 0,0, 0, 0,1, 16'h0002,4'h0,3'd1));
        vecs.push_back(mk("fire_g2_wb1",1,0,0, 0,0, 0,0,0, 0,0, 2,2'b01, 1,1, 0,0, 0, 0,1, 16'h0004,4'h0,3'd1));
        vecs.push_back(mk("fire_g15",  1, 0,0, 0,0, 0,0,0, 0,0,15,2'b01, 0,0, 0,0, 0, 0,1, 16'h8004,4'h0,3'd2));
        vecs.push_back(mk("ry15_haz",  1, 0,0,15,1, 0,0,0, 0,0, 0,2'b00, 0,0, 0,0, 0, 1,0, 16'h8004,4'h0,3'd2));
        vecs.push_back(mk("fire_p1",   1, 0,0, 0,0, 0,0,0, 0,0, 1,2'b10, 0,0, 0,0, 0, 0,1, 16'h8004,4'h2,3'd3));

        // Reset is held across edges with a greg writer presented: it fires but nothing is recorded.
        rst = 1'b1;
        applyStimulus(mk("rst_issue", 1, 0,0, 0,0, 0,0,0, 0,0, 3,2'b01, 0,0, 0,0, 0, 0,1, 16'h0,4'h0,3'd0));
        #2;
        checkOutput("rst.fire", 32'(fire), 32'd1);
        checkOutput("rst.stall", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.greg", 32'(greg_busy), 32'h0);
        checkOutput("rst.preg", 32'(preg_busy), 32'h0);
        checkOutput("rst.infl", 32'(inflight), 32'd0);
        applyStimulus(idle);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i]);
        end

        // Asynchronous reset mid-cycle clears state without waiting for an edge.
        applyStimulus(idle);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst.greg", 32'(greg_busy), 32'h0);
        checkOutput("async_rst.preg", 32'(preg_busy), 32'h0);
        checkOutput("async_rst.infl", 32'(inflight), 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        runVec(mk("stale_wb", 0, 0,0, 0,0, 0,0,0, 0,0, 0,2'b00, 1,15, 1,1, 0, 0,0, 16'h0000,4'h0,3'd0));
        runVec(mk("post_rst_g4", 1, 0,0, 0,0, 0,0,0, 0,0, 4,2'b01, 0,0, 0,0, 0, 0,1, 16'h0010,4'h0,3'd1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
